cpu_wb_arbiter: RTL

CPU_WB_ARBITER -- requirements
Module: CPU_wb_arbiter

---
 rtl/cpu_wb_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_wb_arbiter.sv
// Merges the ALU and multiplier writeback streams onto one registered register-bank
// write port, queueing collisions in a small in-order FIFO with forwarding lookup.
module cpu_wb_arbiter #(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 32,
    parameter int DEPTH     = 4,
    localparam int RID      = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_wb_valid,
    input  logic [RID-1:0]       alu_wb_rd,
    input  logic [REG_WIDTH-1:0] alu_wb_data,
    input  logic                 mul_wb_valid,
    input  logic [RID-1:0]       mul_wb_rd,
    input  logic [REG_WIDTH-1:0] mul_wb_data,
    output logic                 rf_we,
    output logic [RID-1:0]       rf_waddr,
    output logic [REG_WIDTH-1:0] rf_wdata,
    output logic                 stall,
    input  logic [RID-1:0]       qry_rd,
    output logic                 qry_hit,
    output logic [REG_WIDTH-1:0] qry_data,
    output logic                 overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 2);

    logic [CW-1:0]        count_reg, count_next;
    logic [PW-1:0]        rp_reg, rp_next, wp_reg, wp_next, wp1;
    logic [DEPTH-1:0]     fifo_valid_reg;
    logic [RID-1:0]       fifo_rd   [DEPTH];
    logic [REG_WIDTH-1:0] fifo_data [DEPTH];
    logic                 rf_we_reg, overflow_reg;
    logic [RID-1:0]       rf_waddr_reg;
    logic [REG_WIDTH-1:0] rf_wdata_reg;

    logic                 wr_en, drain, acc0, acc1, drop;
    logic [RID-1:0]       wr_rd, c0_rd, c1_rd;
    logic [REG_WIDTH-1:0] wr_data, c0_data, c1_data;
    logic                 c0_v, c1_v;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // c0/c1 are the enqueue candidates in age order (MUL before ALU).
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = mul_wb_rd;
        wr_data = mul_wb_data;
        drain   = 1'b0;
        c0_v    = 1'b0;
        c0_rd   = mul_wb_rd;
        c0_data = mul_wb_data;
        c1_v    = 1'b0;
        c1_rd   = alu_wb_rd;
        c1_data = alu_wb_data;
        if (count_reg == '0) begin
            if (mul_wb_valid) begin
                wr_en = 1'b1;
                if (alu_wb_valid) begin
                    c0_v    = 1'b1;
                    c0_rd   = alu_wb_rd;
                    c0_data = alu_wb_data;
                end
            end else if (alu_wb_valid) begin
                wr_en   = 1'b1;
                wr_rd   = alu_wb_rd;
                wr_data = alu_wb_data;
            end
        end else begin
            drain   = 1'b1;
            wr_en   = 1'b1;
            wr_rd   = fifo_rd[rp_reg];
            wr_data = fifo_data[rp_reg];
            if (mul_wb_valid) begin
                c0_v = 1'b1;
                c1_v = alu_wb_valid;
            end else if (alu_wb_valid) begin
                c0_v    = 1'b1;
                c0_rd   = alu_wb_rd;
                c0_data = alu_wb_data;
            end
        end
        // Fullness is judged on the occupancy before this cycle's drain.
        acc0       = c0_v && (count_reg < DEPTH_C);
        acc1       = c1_v && ((count_reg + CW'(acc0)) < DEPTH_C);
        drop       = (c0_v && !acc0) || (c1_v && !acc1);
        wp1        = ptr_inc(wp_reg);
        wp_next    = acc1 ? ptr_inc(wp1) : (acc0 ? wp1 : wp_reg);
        rp_next    = drain ? ptr_inc(rp_reg) : rp_reg;
        count_next = count_reg + CW'(acc0) + CW'(acc1) - CW'(drain);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            rp_reg       <= '0;
            wp_reg       <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rp_reg       <= rp_next;
            wp_reg       <= wp_next;
            rf_we_reg    <= wr_en;
            overflow_reg <= overflow_reg | drop;
            if (wr_en) begin
                rf_waddr_reg <= wr_rd;
                rf_wdata_reg <= wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    fifo_valid_reg[gi] <= 1'b0;
                end else if ((acc0 && wp_reg == PW'(gi)) || (acc1 && wp1 == PW'(gi))) begin
                    fifo_valid_reg[gi] <= 1'b1;
                end else if (drain && rp_reg == PW'(gi)) begin
                    fifo_valid_reg[gi] <= 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (acc0 && wp_reg == PW'(gi)) begin
                    fifo_rd[gi]   <= c0_rd;
                    fifo_data[gi] <= c0_data;
                end else if (acc1 && wp1 == PW'(gi)) begin
                    fifo_rd[gi]   <= c1_rd;
                    fifo_data[gi] <= c1_data;
                end
            end
        end
    endgenerate

    // Walk oldest to newest so the newest matching entry wins; the write port ranks below all.
    always_comb begin
        int idx;
        qry_hit  = 1'b0;
        qry_data = '0;
        if (rf_we_reg && rf_waddr_reg == qry_rd) begin
            qry_hit  = 1'b1;
            qry_data = rf_wdata_reg;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(rp_reg) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if (fifo_valid_reg[PW'(idx)] && fifo_rd[PW'(idx)] == qry_rd) begin
                qry_hit  = 1'b1;
                qry_data = fifo_data[PW'(idx)];
            end
        end
    end

    assign rf_we        = rf_we_reg;
    assign rf_waddr     = rf_waddr_reg;
    assign rf_wdata     = rf_wdata_reg;
    assign stall        = (count_reg >= STALL_C);
    assign overflow_err = overflow_reg;
endmodule
